output_unit: RTL and testbench
==============================

# output_unit

Per-output-port stage of the router, directly downstream of the input units. Arbitrates round-robin among input units requesting this output, handshakes with the next router's input unit over the link (req/ack), then streams the winner's packet flit-by-flit onto the link until the tail flit. One instance per router output port.

## Interface
Parameters:
- NUM_PORTS, 5: number of input units that can request this output.
- MAX_PKT_FLITS, NUM_OF_FLITS: maximum legal packet length in flits, tail included.
- ACK_TIMEOUT, 16: cycles to wait for i_link_ack before retrying arbitration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_switch_req  in  NUM_PORTS  per-input request for this output. Each input holds its request until it receives o_switch_ack.
- i_flit  in  NUM_PORTS x FLIT_SIZE  per-input flit (FLIT_t). Bit FLIT_SIZE-1 is the valid bit.
- o_switch_ack  out  NUM_PORTS  one-hot grant. High for the whole streaming phase.
- o_link_req  out  1  request to the downstream input unit.
- i_link_ack  in  1  transmit acknowledge from the downstream input unit.
- o_flit  out  FLIT_SIZE  registered flit to the link. All-zero when idle.
- o_busy  out  1  high in any state other than IDLE.
- o_err_len  out  1  sticky flag, set on a packet-length overrun.

## Operation
- States:
  - IDLE → ARB_REQ when any i_switch_req bit is set.
  - ARB_REQ → STREAM on i_link_ack.
  - ARB_REQ → IDLE on timeout, or when the granted i_switch_req drops.
  - STREAM → IDLE on tail flit captured, or on length overrun.
- Arbitration (IDLE only):
  - The first set bit at or after priority pointer ptr (modulo NUM_PORTS) wins.
  - The winner index g is registered; o_link_req is asserted.
- ARB_REQ:
  - o_link_req is held high and a wait counter increments.
  - If the counter reaches ACK_TIMEOUT: go to IDLE, set ptr = g+1, deassert o_link_req.
  - If i_switch_req[g] falls first: go to IDLE without rotating ptr.
- STREAM:
  - o_link_req = 0 and o_switch_ack[g] = 1.
  - Each cycle: o_flit <= i_flit[g] if its valid bit is set, else o_flit <= 0.
  - Each valid flit increments flit_cnt (width $clog2(MAX_PKT_FLITS)+1).
- Tail: a valid flit with tail.flit_type == TAIL_FLIT is forwarded. Next cycle the block is in IDLE, o_switch_ack = 0, ptr = g+1 mod NUM_PORTS, flit_cnt = 0.
- Overrun:
  - Triggered when flit_cnt reaches MAX_PKT_FLITS without a tail.
  - That flit is still forwarded, o_err_len is set, and the block returns to IDLE with ptr rotated.
  - o_err_len clears only on reset.
- Requests from non-granted inputs are ignored outside IDLE. There is no preemption.

## Timing
- Reset values (asynchronous): state IDLE, ptr 0, g 0, counters 0, all outputs 0.
- Request to link: i_switch_req seen high at edge N gives o_link_req = 1 after edge N.
- Link to streaming: i_link_ack sampled high at edge M gives state STREAM and o_switch_ack[g] = 1 after edge M.
- Flit latency is 1 cycle: i_flit[g] valid at edge K appears on o_flit after edge K.
- After a tail: o_flit holds the tail for one cycle, then returns to 0. o_busy falls in the same cycle o_flit shows the tail (state already IDLE).
- Back-to-back packets: IDLE lasts at least one cycle between packets, so a new grant is possible 1 cycle after the tail is captured.
- Simultaneous request and i_link_ack in IDLE: the ack is ignored. Only ARB_REQ samples i_link_ack.
- Reset mid-packet: all outputs are forced to 0 immediately (asynchronous). Any partial packet is discarded by the system.

## Structure
- router_pkg already provides FLIT_t, FLIT_SIZE, TAIL_FLIT and NUM_OF_FLITS.
- Add to router_pkg:
  - OUT_STATE_t enum (IDLE, ARB_REQ, STREAM).
  - Default constant NUM_ROUTER_PORTS = 5.
- One sub-module: rr_arbiter.
  - Combinational; parameter N.
  - Inputs: req vector and ptr. Outputs: grant index and any_req.
  - The output_unit registers its results.

## Test plan
- Single packet: NUM_PORTS=5, input 2 requests; i_link_ack on the 2nd ARB_REQ cycle; 4 flits with the 4th a tail → o_switch_ack=5'b00100 for the 4 stream cycles, 4 flits on o_flit in order with 1-cycle delay, final state IDLE, ptr=3.
- Contention: inputs 0, 1 and 4 request together with ptr=0 → grants in order 0, 1, 4, each packet completing before the next grant.
- Timeout: input 3 requests and i_link_ack never comes, ACK_TIMEOUT=16 → o_link_req high for exactly 16 cycles, then IDLE with ptr=4.
- Overrun: MAX_PKT_FLITS=4, 6 valid flits without a tail → 4 flits forwarded, o_err_len=1, return to IDLE, o_err_len still 1 afterwards.
- Bubbles and reset: invalid flits inserted mid-packet give o_flit=0 and flit_cnt unchanged; reset_n asserted mid-STREAM gives all outputs 0 in the same cycle, state IDLE.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: flit format, output-unit FSM states and port-count defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package router_pkg;

    localparam int NUM_OF_FLITS     = 8;
    localparam int FLIT_DATA_W      = 32;
    localparam int NUM_ROUTER_PORTS = 5;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    // valid sits in the MSB so a zeroed bus is an idle link
    typedef struct packed {
        logic                   valid;
        flit_type_t             flit_type;
        logic [FLIT_DATA_W-1:0] data;
    } FLIT_t;

    localparam int FLIT_SIZE = $bits(FLIT_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB_REQ = 2'd1,
        STREAM  = 2'd2
    } OUT_STATE_t;

    function automatic logic is_tail(input FLIT_t f);
        return f.valid && (f.flit_type == TAIL_FLIT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping modulo N.
// Zero latency; no backpressure, the caller registers the result.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N  = NUM_ROUTER_PORTS,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_any_req
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        o_grant   = '0;
        o_any_req = |i_req;
        w_idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= N) w_idx = w_idx - N;
            if (i_req[w_idx]) o_grant = IW'(w_idx);
        end
    end

endmodule

// File: rtl/output_unit.sv
// Router output port: round-robin grant, req/ack link handshake, then 1-cycle registered flit stream to tail.
// Link backpressure is the ack wait (bounded by ACK_TIMEOUT); inputs hold requests until o_switch_ack.
module output_unit
    import router_pkg::*;
#(
    parameter int NUM_PORTS     = NUM_ROUTER_PORTS,
    parameter int MAX_PKT_FLITS = NUM_OF_FLITS,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_PORTS-1:0]                i_switch_req,
    input  logic [NUM_PORTS-1:0][FLIT_SIZE-1:0] i_flit,
    output logic [NUM_PORTS-1:0]                o_switch_ack,
    output logic                                o_link_req,
    input  logic                                i_link_ack,
    output logic [FLIT_SIZE-1:0]                o_flit,
    output logic                                o_busy,
    output logic                                o_err_len
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(MAX_PKT_FLITS) + 1;
    localparam int WW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PKT_FLITS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

    OUT_STATE_t            r_state,    w_state_nxt;
    logic [IW-1:0]         r_ptr,      w_ptr_nxt;
    logic [IW-1:0]         r_grant,    w_grant_nxt;
    logic [WW-1:0]         r_wait_cnt, w_wait_nxt;
    logic [CW-1:0]         r_flit_cnt, w_cnt_nxt;
    logic [FLIT_SIZE-1:0]  r_flit,     w_flit_nxt;
    logic                  r_err_len,  w_err_nxt;

    logic [IW-1:0]         w_arb_idx;
    logic                  w_any_req;
    logic [IW-1:0]         w_ptr_after;
    logic [CW-1:0]         w_cnt_inc;
    FLIT_t                 w_sel_flit;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_arb (
        .i_req     (i_switch_req),
        .i_ptr     (r_ptr),
        .o_grant   (w_arb_idx),
        .o_any_req (w_any_req)
    );

    assign w_sel_flit  = FLIT_t'(i_flit[r_grant]);
    assign w_ptr_after = (r_grant == LAST_PORT) ? '0 : r_grant + 1'b1;
    assign w_cnt_inc   = r_flit_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_wait_nxt  = '0;
        w_cnt_nxt   = r_flit_cnt;
        w_flit_nxt  = '0;
        w_err_nxt   = r_err_len;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ARB_REQ;
                    w_grant_nxt = w_arb_idx;
                end
            end
            ARB_REQ: begin
                // A withdrawn request cannot be streamed, so it beats a same-cycle ack.
                if (!i_switch_req[r_grant]) begin
                    w_state_nxt = IDLE;
                end else if (i_link_ack) begin
                    w_state_nxt = STREAM;
                    w_cnt_nxt   = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_ptr_after;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 1'b1;
                end
            end
            STREAM: begin
                if (w_sel_flit.valid) begin
                    w_flit_nxt = w_sel_flit;
                    w_cnt_nxt  = w_cnt_inc;
                    if (is_tail(w_sel_flit)) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_ptr_after;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_ptr_after;
                        w_cnt_nxt   = '0;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_wait_cnt <= '0;
            r_flit_cnt <= '0;
            r_flit     <= '0;
            r_err_len  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_flit_cnt <= w_cnt_nxt;
            r_flit     <= w_flit_nxt;
            r_err_len  <= w_err_nxt;
        end
    end

    assign o_switch_ack = (r_state == STREAM) ? (NUM_PORTS'(1) << r_grant) : '0;
    assign o_link_req   = (r_state == ARB_REQ);
    assign o_busy       = (r_state != IDLE);
    assign o_flit       = r_flit;
    assign o_err_len    = r_err_len;

endmodule

// File: tb/tb_output_unit.sv
// Directed bench for output_unit: single packet, timeout, IDLE-ack/drop, contention, overrun, bubbles and reset.
module tb_output_unit;
    import router_pkg::*;

    localparam int NP   = 5;
    localparam int MAXF = 4;
    localparam int TO   = 16;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [NP-1:0]                i_switch_req;
    logic [NP-1:0][FLIT_SIZE-1:0] i_flit;
    logic [NP-1:0]                o_switch_ack;
    logic                         o_link_req;
    logic                         i_link_ack;
    logic [FLIT_SIZE-1:0]         o_flit;
    logic                         o_busy;
    logic                         o_err_len;

    int checks   = 0;
    int failures = 0;

    output_unit #(
        .NUM_PORTS     (NP),
        .MAX_PKT_FLITS (MAXF),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_switch_req (i_switch_req),
        .i_flit       (i_flit),
        .o_switch_ack (o_switch_ack),
        .o_link_req   (o_link_req),
        .i_link_ack   (i_link_ack),
        .o_flit       (o_flit),
        .o_busy       (o_busy),
        .o_err_len    (o_err_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLIT_SIZE-1:0] mk(input logic v, input flit_type_t t, input logic [31:0] d);
        FLIT_t f;
        f.valid     = v;
        f.flit_type = t;
        f.data      = d;
        return f;
    endfunction

    function automatic logic [NP-1:0] onehot(input int g);
        logic [NP-1:0] e;
        e    = '0;
        e[g] = 1'b1;
        return e;
    endfunction

    // Wait for the link request, ack it, then stream a head+tail packet from input g.
    task automatic run_pkt(input int g, input string tag);
        logic [FLIT_SIZE-1:0] f;
        int n;
        n = 0;
        while (!o_link_req && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_link_req"}, o_link_req, 1);
        i_link_ack = 1'b1;
        tick();
        i_link_ack = 1'b0;
        chk({tag, "_grant"}, o_switch_ack, onehot(g));
        i_switch_req[g] = 1'b0;
        f = mk(1'b1, HEAD_FLIT, 32'hA0 + g);
        i_flit[g] = f;
        tick();
        chk({tag, "_head"}, o_flit, f);
        f = mk(1'b1, TAIL_FLIT, 32'hB0 + g);
        i_flit[g] = f;
        tick();
        chk({tag, "_tail"}, o_flit, f);
        chk({tag, "_idle_after_tail"}, o_busy, 0);
        i_flit[g] = '0;
    endtask

    logic [FLIT_SIZE-1:0] pk [4];
    logic [FLIT_SIZE-1:0] fl;
    int                   n;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        i_switch_req = '0;
        i_link_ack   = 1'b0;
        i_flit       = '0;
        tick();
        tick();
        chk("rst_flit", o_flit, 0);
        chk("rst_ack", o_switch_ack, 0);
        chk("rst_link_req", o_link_req, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err_len, 0);
        chk("rst_ptr", dut.r_ptr, 0);
        reset_n = 1'b1;
        tick();

        // Single packet from input 2, ack on the second ARB_REQ cycle.
        pk[0] = mk(1'b1, HEAD_FLIT, 32'h11);
        pk[1] = mk(1'b1, BODY_FLIT, 32'h22);
        pk[2] = mk(1'b1, BODY_FLIT, 32'h33);
        pk[3] = mk(1'b1, TAIL_FLIT, 32'h44);
        i_switch_req = 5'b00100;
        tick();
        chk("sp_link_req_c1", o_link_req, 1);
        chk("sp_busy_c1", o_busy, 1);
        chk("sp_no_ack_c1", o_switch_ack, 0);
        tick();
        chk("sp_link_req_c2", o_link_req, 1);
        i_link_ack = 1'b1;
        tick();
        i_link_ack = 1'b0;
        chk("sp_link_req_stream", o_link_req, 0);
        i_switch_req = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sp_ack_%0d", k), o_switch_ack, 5'b00100);
            i_flit[2] = pk[k];
            tick();
            chk($sformatf("sp_flit_%0d", k), o_flit, pk[k]);
        end
        chk("sp_busy_after_tail", o_busy, 0);
        chk("sp_ack_after_tail", o_switch_ack, 0);
        chk("sp_ptr", dut.r_ptr, 3);
        chk("sp_cnt", dut.r_flit_cnt, 0);
        i_flit[2] = '0;
        tick();
        chk("sp_flit_zero", o_flit, 0);

        // Timeout on input 3 with ptr=3.
        i_switch_req = 5'b01000;
        tick();
        n = 0;
        for (int i = 0; i < 40 && o_link_req; i++) begin
            n++;
            tick();
        end
        chk("to_link_req_cycles", n, TO);
        chk("to_busy", o_busy, 0);
        chk("to_ptr", dut.r_ptr, 4);
        i_switch_req = '0;
        tick();

        // Ack in IDLE is ignored; a dropped request returns to IDLE without rotating.
        i_switch_req = 5'b00001;
        i_link_ack   = 1'b1;
        tick();
        chk("ia_no_stream", o_switch_ack, 0);
        chk("ia_link_req", o_link_req, 1);
        i_link_ack   = 1'b0;
        i_switch_req = '0;
        tick();
        chk("drop_busy", o_busy, 0);
        chk("drop_ptr", dut.r_ptr, 4);

        // Contention from ptr 0 after an asynchronous reset pulse.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        chk("ct_ptr0", dut.r_ptr, 0);
        i_switch_req = 5'b10011;
        run_pkt(0, "ct0");
        run_pkt(1, "ct1");
        run_pkt(4, "ct4");
        chk("ct_ptr_wrap", dut.r_ptr, 0);
        tick();

        // Overrun: six untailed flits from input 1 with MAX_PKT_FLITS=4.
        i_switch_req = 5'b00010;
        tick();
        chk("ov_link_req", o_link_req, 1);
        i_link_ack = 1'b1;
        tick();
        i_link_ack   = 1'b0;
        i_switch_req = '0;
        chk("ov_grant", o_switch_ack, 5'b00010);
        for (int k = 0; k < 6; k++) begin
            fl = mk(1'b1, (k == 0) ? HEAD_FLIT : BODY_FLIT, 32'h50 + k);
            i_flit[1] = fl;
            tick();
            if (k < 4) chk($sformatf("ov_flit_%0d", k), o_flit, fl);
            else       chk($sformatf("ov_drop_%0d", k), o_flit, 0);
            if (k == 3) begin
                chk("ov_err", o_err_len, 1);
                chk("ov_busy", o_busy, 0);
            end
        end
        i_flit[1] = '0;
        chk("ov_err_sticky", o_err_len, 1);
        chk("ov_ptr", dut.r_ptr, 2);
        chk("ov_cnt", dut.r_flit_cnt, 0);

        // Bubbles then reset mid-stream on input 2.
        i_switch_req = 5'b00100;
        tick();
        i_link_ack = 1'b1;
        tick();
        i_link_ack   = 1'b0;
        i_switch_req = '0;
        chk("bb_grant", o_switch_ack, 5'b00100);
        fl = mk(1'b1, HEAD_FLIT, 32'h61);
        i_flit[2] = fl;
        tick();
        chk("bb_head", o_flit, fl);
        chk("bb_cnt1", dut.r_flit_cnt, 1);
        i_flit[2] = mk(1'b0, BODY_FLIT, 32'h62);
        tick();
        chk("bb_bubble_flit", o_flit, 0);
        chk("bb_bubble_cnt", dut.r_flit_cnt, 1);
        chk("bb_bubble_busy", o_busy, 1);
        fl = mk(1'b1, BODY_FLIT, 32'h63);
        i_flit[2] = fl;
        tick();
        chk("bb_body", o_flit, fl);
        chk("bb_cnt2", dut.r_flit_cnt, 2);
        reset_n = 1'b0;
        #1;
        chk("mr_flit", o_flit, 0);
        chk("mr_ack", o_switch_ack, 0);
        chk("mr_link_req", o_link_req, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_err", o_err_len, 0);
        chk("mr_ptr", dut.r_ptr, 0);
        i_flit = '0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
